aes128_inv_key_sched: RTL and testbench

//   Inverse AES-128 key schedule. Takes the last round key (round NR) and walks the key

---
 rtl/aes128_inv_key_sched.sv | 83 ++++++++
 tb/tb_aes128_inv_key_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aes128_inv_key_sched.sv
// aes128_inv_key_sched: walks the AES-128 key expansion backwards from round key NR down to 0.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, key_in     begin a walk from round key NR (sampled in IDLE only)
//   busy              high from the cycle after start until done
//   rk_out, rk_idx    current round key and its round index
//   rk_valid/rk_ready valid/ready handshake for rk_out/rk_idx
//   done              one-cycle pulse after round key 0 is accepted
//   sbox_in/sbox_out  shared combinational 4-byte forward S-box
module aes128_inv_key_sched #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_LAST = 8'h36,
    parameter bit         ZEROIZE   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out
);
    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;
    state_t       state;
    logic [127:0] key;
    logic [7:0]   rcon;
    logic [31:0]  b0, b1, b2, b3;
    logic [7:0]   rcon_prev;
    // Undo w[i] = w[i-4] ^ w[i-1] for words 1..3; word 0 needs SubWord(RotWord(w[i-1])) ^ Rcon.
    assign b3        = key[31:0] ^ key[63:32];
    assign b2        = key[63:32] ^ key[95:64];
    assign b1        = key[95:64] ^ key[127:96];
    assign b0        = key[127:96] ^ sbox_out ^ {rcon, 24'h0};
    assign sbox_in   = (state == IDLE) ? 32'h0 : {b3[23:0], b3[31:24]};
    assign rk_out    = key;
    // Division by x in GF(2^8): 0x11b >> 1 = 0x8d, the dropped low bit cancels r[0].
    assign rcon_prev = rcon[0] ? ((rcon >> 1) ^ 8'h8d) : (rcon >> 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            key      <= '0;
            rcon     <= RCON_LAST;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    key      <= key_in;
                    rk_idx   <= 4'(NR);
                    rcon     <= RCON_LAST;
                    rk_valid <= 1'b1;
                    busy     <= 1'b1;
                    state    <= EMIT;
                end
                EMIT: if (rk_ready) begin
                    if (rk_idx != 4'd0) begin
                        key    <= {b0, b1, b2, b3};
                        rk_idx <= rk_idx - 4'd1;
                        rcon   <= rcon_prev;
                    end else begin
                        rk_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    key   <= ZEROIZE ? '0 : key;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// tb_aes128_inv_key_sched: vector and random checks of the inverse key schedule against a forward-expansion model.
module tb_aes128_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst, start, rk_ready;
    logic [127:0] key_in;
    logic         busy, rk_valid, done, busy_nz, rk_valid_nz, done_nz;
    logic [127:0] rk_out, rk_out_nz;
    logic [3:0]   rk_idx, rk_idx_nz;
    logic [31:0]  sbox_in, sbox_out, sbox_in_nz, sbox_out_nz;
    logic [7:0]   sbox [0:255];
    logic [127:0] model [0:10];
    logic [127:0] got_key [0:10];
    logic [3:0]   got_idx [0:10];
    int           acc_cyc [0:10];
    int           n_acc, early_done;
    int           errors = 0, checks = 0;
    typedef struct {
        logic [127:0] key10;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl [0:3];
    always #5 clk = ~clk;
    assign sbox_out    = {sbox[sbox_in[31:24]], sbox[sbox_in[23:16]], sbox[sbox_in[15:8]], sbox[sbox_in[7:0]]};
    assign sbox_out_nz = {sbox[sbox_in_nz[31:24]], sbox[sbox_in_nz[23:16]], sbox[sbox_in_nz[15:8]], sbox[sbox_in_nz[7:0]]};
    aes128_inv_key_sched dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy), .rk_out(rk_out),
        .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready), .done(done),
        .sbox_in(sbox_in), .sbox_out(sbox_out));
    aes128_inv_key_sched #(.ZEROIZE(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy_nz), .rk_out(rk_out_nz),
        .rk_idx(rk_idx_nz), .rk_valid(rk_valid_nz), .rk_ready(rk_ready), .done(done_nz),
        .sbox_in(sbox_in_nz), .sbox_out(sbox_out_nz));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Forward FIPS-197 key expansion; model[r] is round key r.
    task automatic fill_model(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // mode 0: ready always, 1: random ready, 2: 5-cycle stall at idx 7, 3: start pulses in EMIT and FIN
    task automatic walk(input int mode);
        int  stall = 0;
        bit  last = 0;
        n_acc = 0;
        early_done = 0;
        for (int i = 0; i <= 10; i++) begin
            got_key[i] = '0;
            got_idx[i] = '0;
            acc_cyc[i] = 0;
        end
        start = 1'b1;
        key_in = model[10];
        tick;
        start = 1'b0;
        key_in = ~model[10];
        chk("first_valid", {rk_valid, busy, rk_idx}, {1'b1, 1'b1, 4'd10});
        for (int cyc = 0; cyc < 200 && !last; cyc++) begin
            if (mode == 2 && rk_idx == 4'd7 && stall < 5) begin
                rk_ready = 1'b0;
                stall++;
                chk("stall_key", rk_out, model[7]);
                chk("stall_idx", {rk_valid, rk_idx}, {1'b1, 4'd7});
            end else
                rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (mode == 3 && cyc == 2);
            if (done) early_done++;
            if (rk_valid && rk_ready && n_acc < 11) begin
                got_key[n_acc] = rk_out;
                got_idx[n_acc] = rk_idx;
                acc_cyc[n_acc] = cyc;
                n_acc++;
                last = (rk_idx == 4'd0);
            end
            tick;
        end
        start = 1'b0;
        chk("accept_count", n_acc, 11);
        chk("no_early_done", early_done, 0);
        chk("done_pulse", {done, busy, rk_valid}, 3'b110);
        start = (mode == 3);
        tick;
        start = 1'b0;
        chk("done_end", {done, busy, rk_valid}, 3'b000);
        for (int i = 0; i <= 10; i++)
            chk("key_seq", {got_idx[i], got_key[i]}, {4'(10 - i), model[10 - i]});
        if (mode == 2) chk("stall_cycles", stall, 5);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rk_ready = 1'b0;
        key_in = '0;
        build_sbox;
        tbl[0] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[3] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        tick;
        tick;
        chk("reset_outs", {busy, rk_valid, done, rk_idx, rk_out, sbox_in}, '0);
        rst = 1'b0;
        tick;
        chk("idle_hold", {busy, rk_valid, done}, 3'b000);
        fill_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("model_fips10", model[10], tbl[0].key10);
        walk(0);
        for (int i = 0; i < 4; i++)
            chk("fips_vec", {got_idx[10 - tbl[i].idx], got_key[10 - tbl[i].idx]}, {tbl[i].idx, tbl[i].exp});
        chk("consecutive", acc_cyc[10] - acc_cyc[0], 10);
        chk("zeroize_rk", rk_out, '0);
        chk("zeroize_sbox", sbox_in, '0);
        chk("nz_retain", rk_out_nz, model[0]);
        walk(2);
        walk(1);
        walk(3);
        walk(0);
        start = 1'b1;
        key_in = model[10];
        tick;
        start = 1'b0;
        rk_ready = 1'b1;
        for (int i = 0; i < 20 && rk_idx != 4'd4; i++) tick;
        chk("at_idx4", {rk_valid, rk_idx, rk_out}, {1'b1, 4'd4, model[4]});
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_reset", {busy, rk_valid, done, rk_idx, rk_out, sbox_in}, '0);
        tick;
        chk("mid_reset_nodone", {busy, rk_valid, done}, 3'b000);
        walk(0);
        repeat (4) begin
            fill_model({$urandom, $urandom, $urandom, $urandom});
            walk(1);
            chk("rand_zeroize", {rk_out, sbox_in}, '0);
            chk("rand_nz_retain", rk_out_nz, model[0]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
